// File: rtl/bcd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : bcd_pkg                                                |
// | Brief   : Shared BCD digit constants and the digit saturation    |
// |           helper for the BCD down counter.                       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package bcd_pkg;

   localparam int               DIGIT_W  = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
   localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

   // Codes 10..15 are not legal BCD; clamp them to the largest digit.
   function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : bcd_down_digit                                         |
// | Brief   : One BCD digit register with load, decrement and a      |
// |           borrow-chain output to the next more-significant digit.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module bcd_down_digit
   import bcd_pkg::*;
(
   input  logic               clk,
   input  logic               clr,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_d,
   input  logic               dec_in,
   output logic [DIGIT_W-1:0] d,
   output logic               dig_zero,
   output logic               dec_out
);

   assign dig_zero = (d == BCD_ZERO);
   assign dec_out  = dec_in & dig_zero;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         d <= BCD_ZERO;
      end else if (load) begin
         d <= bcd_sat(load_d);
      end else if (dec_in) begin
         d <= dig_zero ? BCD_MAX : d - 4'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bcd_down_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : bcd_down_counter                                       |
// | Brief   : Cascadable DIGITS-digit BCD down counter with load,    |
// |           zero and borrow. Define BCD_DOWN_AUTORELOAD_EN to      |
// |           reload load_val instead of wrapping to all nines.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module bcd_down_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
)(
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      en,
   input  logic                      load,
   input  logic [DIGIT_W*DIGITS-1:0] load_val,
   output logic [DIGIT_W*DIGITS-1:0] q,
   output logic                      zero,
   output logic                      borrow
);

   logic [DIGITS:0]   w_dec;
   logic [DIGITS-1:0] w_dig_zero;
   logic              w_load;

   // Top of the borrow chain is en with every digit at zero.
   assign w_dec[0] = en;
   assign zero     = &w_dig_zero;
   assign borrow   = w_dec[DIGITS] & ~load & clr;

`ifdef BCD_DOWN_AUTORELOAD_EN
   assign w_load = load | w_dec[DIGITS];
`else
   assign w_load = load;
`endif

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         bcd_down_digit u_digit (
            .clk      (clk),
            .clr      (clr),
            .load     (w_load),
            .load_d   (load_val[i*DIGIT_W +: DIGIT_W]),
            .dec_in   (w_dec[i]),
            .d        (q[i*DIGIT_W +: DIGIT_W]),
            .dig_zero (w_dig_zero[i]),
            .dec_out  (w_dec[i+1])
         );
      end
   endgenerate

endmodule
`default_nettype wire
